// File: rtl/draw_rect_ctl_pkg.sv
// Shared constants and helpers for the rectangle position controller.
//   VGA_V_PIXELS : visible lines of the VGA mode (default vertical limit)
//   POS_W        : pixel coordinate width
//   VEL_W        : velocity width (unsigned, saturating)
//   SUM_W        : width of position + velocity sums (one guard bit, no wrap)
package draw_rect_ctl_pkg;

   localparam int unsigned VGA_V_PIXELS = 600;
   localparam int unsigned POS_W        = 12;
   localparam int unsigned VEL_W        = 8;
   localparam int unsigned SUM_W        = POS_W + 1;

   localparam logic [VEL_W-1:0] VEL_MAX = '1;

   // Velocity add that clamps at VEL_MAX instead of wrapping.
   function automatic logic [VEL_W-1:0] vel_sat_add(input logic [VEL_W-1:0] v,
                                                    input logic [VEL_W-1:0] inc);
      logic [VEL_W:0] s;
      s = {1'b0, v} + {1'b0, inc};
      return s[VEL_W] ? VEL_MAX : s[VEL_W-1:0];
   endfunction

endpackage

// File: rtl/draw_rect_ctl_rise_edge.sv
// Registered-history rising-edge detector.
//   clk, rst  : clock, synchronous active-high reset
//   sig_i     : level input, synchronous to clk
//   rise_c_o  : combinational pulse, high when sig_i is high and was low last cycle
module rise_edge (
   input  logic clk,
   input  logic rst,
   input  logic sig_i,
   output logic rise_c_o
);

   logic sig_q;

   // Previous-cycle copy of the input.
   always_ff @(posedge clk) begin
      if (rst) sig_q <= 1'b0;
      else     sig_q <= sig_i;
   end

   assign rise_c_o = sig_i & ~sig_q;

endmodule

// File: rtl/draw_rect_ctl.sv
// Rectangle position controller: follows the mouse in idle, drops the
// rectangle under per-frame gravity on a left press, bounces it off the
// floor with decaying velocity, then rests until the next press.
//   clk, rst   : pixel clock, synchronous active-high reset
//   vblnk      : vertical blanking; rising edge is the frame tick
//   mouse_left : left button level (synchronous)
//   mouse_xpos : pointer x
//   mouse_ypos : pointer y
//   xpos, ypos : registered rectangle origin
module draw_rect_ctl
   import draw_rect_ctl_pkg::*;
#(
   parameter int unsigned RECT_HEIGHT  = 100,
   parameter int unsigned V_LIMIT      = VGA_V_PIXELS,
   parameter int unsigned GRAVITY      = 1,
   parameter int unsigned BOUNCE_SHIFT = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             vblnk,
   input  logic             mouse_left,
   input  logic [POS_W-1:0] mouse_xpos,
   input  logic [POS_W-1:0] mouse_ypos,
   output logic [POS_W-1:0] xpos,
   output logic [POS_W-1:0] ypos
);

   localparam logic [POS_W-1:0] FLOOR = POS_W'(V_LIMIT - RECT_HEIGHT);
   localparam logic [VEL_W-1:0] GRAV  = VEL_W'(GRAVITY);

   typedef enum logic [1:0] {
      S_IDLE,
      S_FALL,
      S_RISE,
      S_DONE
   } state_e;

   state_e           state_q, state_d;
   logic [POS_W-1:0] xpos_q, xpos_d;
   logic [POS_W-1:0] ypos_q, ypos_d;
   logic [VEL_W-1:0] vel_q, vel_d;

   logic             tick_c;
   logic             press_c;
   logic [SUM_W-1:0] fall_sum_c;
   logic [VEL_W-1:0] bounce_vel_c;

   rise_edge u_vblnk_edge (
      .clk      (clk),
      .rst      (rst),
      .sig_i    (vblnk),
      .rise_c_o (tick_c)
   );

   rise_edge u_left_edge (
      .clk      (clk),
      .rst      (rst),
      .sig_i    (mouse_left),
      .rise_c_o (press_c)
   );

   // Next state, position and velocity.
   always_comb begin
      state_d      = state_q;
      xpos_d       = xpos_q;
      ypos_d       = ypos_q;
      vel_d        = vel_q;
      fall_sum_c   = {1'b0, ypos_q} + SUM_W'(vel_q);
      bounce_vel_c = vel_q >> BOUNCE_SHIFT;

      case (state_q)
         S_IDLE: begin
            xpos_d = mouse_xpos;
            ypos_d = (mouse_ypos > FLOOR) ? FLOOR : mouse_ypos;
            // A tick coinciding with the press is deliberately not applied.
            if (press_c) begin
               state_d = S_FALL;
               vel_d   = '0;
            end
         end
         S_FALL: begin
            if (tick_c) begin
               if (fall_sum_c >= {1'b0, FLOOR}) begin
                  ypos_d  = FLOOR;
                  vel_d   = bounce_vel_c;
                  state_d = (bounce_vel_c == '0) ? S_DONE : S_RISE;
               end else begin
                  ypos_d = fall_sum_c[POS_W-1:0];
                  vel_d  = vel_sat_add(vel_q, GRAV);
               end
            end
         end
         S_RISE: begin
            if (tick_c) begin
               ypos_d = (ypos_q > POS_W'(vel_q)) ? ypos_q - POS_W'(vel_q) : '0;
               if (vel_q > GRAV) begin
                  vel_d = vel_q - GRAV;
               end else begin
                  vel_d   = '0;
                  state_d = S_FALL;
               end
            end
         end
         S_DONE: begin
            if (press_c) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and position registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         xpos_q  <= '0;
         ypos_q  <= '0;
         vel_q   <= '0;
      end else begin
         state_q <= state_d;
         xpos_q  <= xpos_d;
         ypos_q  <= ypos_d;
         vel_q   <= vel_d;
      end
   end

   assign xpos = xpos_q;
   assign ypos = ypos_q;

endmodule

// File: tb/tb_draw_rect_ctl.sv
// Self-checking bench for draw_rect_ctl: a signed-velocity motion model is
// stepped alongside the DUT and compared every cycle; literal expectations
// (reset, clamp, the drop trace) pin the model itself.
module tb_draw_rect_ctl;

   localparam int FLOOR_Y = 500;
   localparam int GRAV    = 1;
   localparam int SHIFT   = 1;

   logic        clk = 1'b0;
   logic        rst;
   logic        vblnk;
   logic        mouse_left;
   logic [11:0] mouse_xpos;
   logic [11:0] mouse_ypos;
   logic [11:0] xpos;
   logic [11:0] ypos;

   int checks = 0;
   int errors = 0;

   // Model: phase 0 = tracking, 1 = moving, 2 = resting.
   // Moving velocity is signed: >= 0 downward, < 0 upward.
   int m_phase, m_x, m_y, m_v;
   int m_prev_vblnk, m_prev_left;

   int trace [0:12];

   draw_rect_ctl dut (
      .clk        (clk),
      .rst        (rst),
      .vblnk      (vblnk),
      .mouse_left (mouse_left),
      .mouse_xpos (mouse_xpos),
      .mouse_ypos (mouse_ypos),
      .xpos       (xpos),
      .ypos       (ypos)
   );

   always #5 clk = ~clk;

   task automatic model_update();
      int tick, press, s, nv;
      if (rst) begin
         m_phase = 0; m_x = 0; m_y = 0; m_v = 0;
         m_prev_vblnk = 0; m_prev_left = 0;
         return;
      end
      tick  = (vblnk && !m_prev_vblnk) ? 1 : 0;
      press = (mouse_left && !m_prev_left) ? 1 : 0;
      m_prev_vblnk = int'(vblnk);
      m_prev_left  = int'(mouse_left);
      if (m_phase == 0) begin
         m_x = int'(mouse_xpos);
         m_y = (int'(mouse_ypos) < FLOOR_Y) ? int'(mouse_ypos) : FLOOR_Y;
         if (press != 0) begin
            m_phase = 1;
            m_v     = 0;
         end
      end else if (m_phase == 1) begin
         if (tick != 0) begin
            if (m_v >= 0) begin
               if (m_y + m_v >= FLOOR_Y) begin
                  m_y = FLOOR_Y;
                  nv  = m_v / (1 << SHIFT);
                  if (nv == 0) begin
                     m_phase = 2;
                     m_v     = 0;
                  end else begin
                     m_v = -nv;
                  end
               end else begin
                  m_y = m_y + m_v;
                  m_v = (m_v + GRAV > 255) ? 255 : m_v + GRAV;
               end
            end else begin
               s   = -m_v;
               m_y = (m_y > s) ? m_y - s : 0;
               m_v = (s > GRAV) ? -(s - GRAV) : 0;
            end
         end
      end else begin
         if (press != 0) m_phase = 0;
      end
   endtask

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
      end
   endtask

   // One clock: advance the model on this cycle's inputs, then compare.
   task automatic step();
      model_update();
      @(negedge clk);
      check("model_xpos", int'(xpos), m_x);
      check("model_ypos", int'(ypos), m_y);
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic frame();
      vblnk = 1'b1;
      steps(3);
      vblnk = 1'b0;
      steps(5);
   endtask

   task automatic press_release();
      mouse_left = 1'b1;
      step();
      mouse_left = 1'b0;
      step();
   endtask

   task automatic set_mouse(input int x, input int y);
      mouse_xpos = 12'(x);
      mouse_ypos = 12'(y);
   endtask

   initial begin
      trace = '{490, 491, 493, 496, 500, 498, 497, 497, 498, 500, 499, 499, 500};
      m_phase = 0; m_x = 0; m_y = 0; m_v = 0; m_prev_vblnk = 0; m_prev_left = 0;
      rst = 1'b1; vblnk = 1'b0; mouse_left = 1'b0;
      set_mouse(300, 200);
      @(negedge clk);

      // Reset: zeros during reset, mouse one cycle after release.
      steps(2);
      check("reset_xpos", int'(xpos), 0);
      check("reset_ypos", int'(ypos), 0);
      rst = 1'b0;
      step();
      check("post_reset_xpos", int'(xpos), 300);
      check("post_reset_ypos", int'(ypos), 200);

      // Clamp to floor, x tracking with one cycle latency.
      set_mouse(10, 550);
      step();
      check("clamp_ypos", int'(ypos), 500);
      check("clamp_xpos", int'(xpos), 10);
      mouse_xpos = 12'd77;
      step();
      check("track_xpos", int'(xpos), 77);

      // Drop from 490 with the literal trace; mouse moves are ignored.
      set_mouse(50, 490);
      step();
      press_release();
      set_mouse(999, 10);
      for (int i = 0; i < 13; i++) begin
         frame();
         check($sformatf("trace_%0d", i), int'(ypos), trace[i]);
         if (i == 2) begin
            // No tick for 2000 cycles, with presses that must be ignored.
            for (int k = 0; k < 1000; k++) begin
               mouse_left = k[3];
               step();
               mouse_left = 1'b0;
               step();
            end
            check("no_tick_hold", int'(ypos), 493);
         end
      end
      check("frozen_xpos", int'(xpos), 50);
      for (int i = 0; i < 3; i++) frame();
      check("done_hold", int'(ypos), 500);

      // Back to tracking, then a drop with the button held throughout.
      press_release();
      set_mouse(20, 495);
      steps(2);
      check("retrack_ypos", int'(ypos), 495);
      mouse_left = 1'b1;
      step();
      for (int i = 0; i < 20; i++) frame();
      set_mouse(20, 100);
      steps(4);
      check("held_done_ypos", int'(ypos), 500);
      mouse_left = 1'b0;
      step();
      press_release();
      step();
      check("held_retrack_ypos", int'(ypos), 100);
      press_release();
      set_mouse(600, 50);
      step();
      check("redrop_xpos", int'(xpos), 20);
      frame();
      check("redrop_t0", int'(ypos), 100);
      frame();
      check("redrop_t1", int'(ypos), 101);

      // Reset during the rise, then a fresh drop starts from zero velocity.
      rst = 1'b1;
      step();
      rst = 1'b0;
      set_mouse(50, 490);
      steps(2);
      press_release();
      for (int i = 0; i < 6; i++) frame();
      check("rise_ypos", int'(ypos), 498);
      set_mouse(5, 300);
      rst = 1'b1;
      step();
      check("midrise_reset_ypos", int'(ypos), 0);
      rst = 1'b0;
      step();
      check("midrise_track_ypos", int'(ypos), 300);
      check("midrise_track_xpos", int'(xpos), 5);
      press_release();
      frame();
      check("fresh_t0", int'(ypos), 300);
      frame();
      check("fresh_t1", int'(ypos), 301);
      frame();
      check("fresh_t2", int'(ypos), 303);

      // Press and tick in the same idle cycle: only the transition happens.
      rst = 1'b1;
      step();
      rst = 1'b0;
      set_mouse(7, 480);
      steps(2);
      vblnk = 1'b1;
      mouse_left = 1'b1;
      step();
      mouse_left = 1'b0;
      steps(2);
      vblnk = 1'b0;
      steps(5);
      check("press_tick_ypos", int'(ypos), 480);
      frame();
      check("press_tick_t0", int'(ypos), 480);
      frame();
      check("press_tick_t1", int'(ypos), 481);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/draw_rect_ctl.md
# draw_rect_ctl

Position controller for the rectangle overlay stage, directly upstream of the rectangle drawer in the mouse pipeline. In idle it makes the rectangle follow the mouse pointer. A left-button press drops the rectangle under frame-rate gravity. It bounces off the bottom edge with decaying velocity until it rests, then waits for the next press. Outputs `xpos`/`ypos` are registered and feed the drawer's rectangle origin.

## Interface
- `RECT_HEIGHT`, default 100: rectangle height in pixels; floor is derived from it.
- `V_LIMIT`, default 600: visible lines; `FLOOR = V_LIMIT - RECT_HEIGHT` (500 at defaults).
- `GRAVITY`, default 1: velocity increment per frame (px/frame²), 1..15.
- `BOUNCE_SHIFT`, default 1: on floor hit, velocity becomes `vel >> BOUNCE_SHIFT`.
- `clk` in 1: pixel clock.
- `rst` in 1: reset, synchronous, active-high.
- `vblnk` in 1: vertical blanking from the timing bus; its rising edge is the frame tick.
- `mouse_left` in 1: left button level, already synchronous to `clk`.
- `mouse_xpos` in 12: pointer x.
- `mouse_ypos` in 12: pointer y.
- `xpos` out 12: rectangle origin x, registered.
- `ypos` out 12: rectangle origin y, registered.

## Operation
- `tick = vblnk & ~vblnk_q`.
- `press = mouse_left & ~left_q`.
- `vel` is 8-bit unsigned and saturates at 255.
- Height sums are computed 13 bits wide, with no wrap.

States:
- **IDLE**
  - Each cycle: `xpos <= mouse_xpos` and `ypos <= min(mouse_ypos, FLOOR)`.
  - On `press`: go to FALL with `vel <= 0`. `xpos`/`ypos` take this cycle's tracking values.
- **FALL**, evaluated only on `tick`:
  - If `ypos + vel >= FLOOR`: `ypos <= FLOOR` and `vel <= vel >> BOUNCE_SHIFT`. If that new `vel == 0`, go to DONE; otherwise go to RISE.
  - Otherwise: `ypos <= ypos + vel` and `vel <= sat(vel + GRAVITY)`.
- **RISE**, evaluated only on `tick`:
  - `ypos <= (ypos > vel) ? ypos - vel : 0`.
  - If `vel > GRAVITY`: `vel <= vel - GRAVITY` and stay in RISE.
  - Otherwise: `vel <= 0` and go to FALL.
- **DONE**: hold `xpos`/`ypos`. On `press`, go to IDLE.

Rules and boundary conditions:
- `xpos` is frozen in FALL, RISE and DONE; `mouse_xpos` and `mouse_ypos` are ignored there.
- `press` is ignored in FALL and RISE.
- A button held across the DONE→IDLE transition does not re-trigger a drop; a fresh edge is required.
- A press and a tick in the same cycle in IDLE: only the transition happens. The first tick counts from the following frame.
- Reset mid-flight forces IDLE immediately; there is no residual velocity.

## Timing
Reset values, all registers:
- state IDLE
- `xpos = 0`, `ypos = 0`
- `vel = 0`
- `vblnk_q = 0`, `left_q = 0`

If `vblnk` is high on the first cycle after reset, that cycle is a tick; this is harmless because the block is in IDLE.

Latency:
- IDLE tracking: 1 cycle from mouse input to `xpos`/`ypos`.
- In FALL/RISE, `ypos` updates at the clock edge following the cycle where `tick` is high. Exactly one update per frame.
- With no tick, `ypos` is constant regardless of cycle count.
- `press` to state FALL: 1 cycle. The first motion happens on the next tick.

## Structure
- `V_LIMIT` defaults come from the shared VGA package's vertical pixel constant.
- The state enum typedef is local to the module; the package is not extended for it.
- One natural sub-module, `rise_edge`: a registered-history rising-edge detector. It is instantiated twice, for `vblnk` and `mouse_left`.
- The rest is a single next-state/next-position comb block plus one register block.

## Test plan
- **Reset:** assert `rst` 2 cycles with mouse at (300,200) → `xpos = ypos = 0` during reset; (300,200) one cycle after release.
- **Clamp:** IDLE with `mouse_ypos = 550`, `mouse_xpos = 10` → `ypos = 500`, `xpos = 10` next cycle. `mouse_xpos` changes are reflected 1 cycle later.
- **Drop trace** (defaults, press at `ypos = 490`) → `ypos` per tick:
  - 490, 491, 493, 496, 500 (floor, `vel` 2)
  - 498, 497 (FALL)
  - 497, 498, 500 (floor, `vel` 1)
  - 499 (FALL)
  - 499, 500 (floor, `vel` 0) → DONE; `ypos` stays 500 thereafter.
- **No tick:** in FALL, hold `vblnk` low 2000 cycles → `ypos` unchanged. One `vblnk` pulse → exactly one update.
- **Held button:** keep `mouse_left` high from press through DONE → stays DONE. Release, then press → IDLE and tracking resumes. Press again → new drop.
- **Reset mid-fall:** `rst` during RISE → IDLE. Next cycle `ypos` follows the mouse and `vel` reads 0 on the following drop.
